m68k_dtack_responder: RTL and testbench

Bus-target side of the 68000 asynchronous handshake. It watches raw AS/UDS/LDS/RW from the 68000 bus and forwards one access request per bus cycle to local target logic. Once the target acknowledges, it drives DTACK aligned to an MCCLK rising edge, after an optional number of wait states, and releases DTACK when AS negates. It is the counterpart of the initiator-side MCCLK/DTACK synchronizer and uses the same sampled-MCCLK edge detection.

---
 rtl/m68k_dtack_responder.sv | 164 ++++++++++++++++
 tb/tb_m68k_dtack_responder.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m68k_dtack_responder.sv
`timescale 1ns/1ps
// 68000 bus-target DTACK responder: synchronizes the raw bus strobes, issues one local
// request per bus cycle and drives DTACK on an MCCLK rising edge after optional wait states.
module m68k_dtack_responder #(
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic       SYSCLK,
   input  logic       RESET,
   input  logic       MCCLK,
   input  logic       AS,
   input  logic       UDS,
   input  logic       LDS,
   input  logic       RW,
   input  logic       SELECT,
   output logic       REQ,
   output logic       REQ_WRITE,
   output logic [1:0] REQ_BE,
   input  logic       ACK,
   output logic       DATA_OE,
   output logic       DTACK_OUT,
   output logic       DTACK_OE
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_ACK,
      S_WAIT_CNT,
      S_WAIT_EDGE,
      S_ASSERT,
      S_RELEASE
   } state_t;

   localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES);

   logic [4:0] meta_q;
   logic [4:0] sync_q;
   logic       mc_hist_q;
   logic       mc_rise_q;
   logic       mc_fall_q;
   logic       mc_s;
   logic       as_s;
   logic       uds_s;
   logic       lds_s;
   logic       rw_s;
   logic       ds_any;

   // NOTE: the synchronizer and edge flops carry no reset; they only follow the pins, and a reset
   // value would fake an AS-high sample that re-arms a strobe held low across RESET.
   always_ff @(posedge SYSCLK) begin
      meta_q    <= {MCCLK, AS, UDS, LDS, RW};
      sync_q    <= meta_q;
      mc_hist_q <= mc_s;
      mc_rise_q <= mc_s & ~mc_hist_q;
      mc_fall_q <= ~mc_s & mc_hist_q;
   end

   assign {mc_s, as_s, uds_s, lds_s, rw_s} = sync_q;
   assign ds_any = ~uds_s | ~lds_s;

   state_t     state_q;
   state_t     state_d;
   logic [3:0] cnt_q;
   logic [3:0] cnt_d;
   logic       armed_q;
   logic       armed_d;
   logic       req_q;
   logic       req_d;
   logic       req_write_q;
   logic       req_write_d;
   logic [1:0] req_be_q;
   logic [1:0] req_be_d;

   always_ff @(posedge SYSCLK) begin
      if (RESET) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         armed_q     <= 1'b0;
         req_q       <= 1'b0;
         req_write_q <= 1'b0;
         req_be_q    <= 2'b00;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         armed_q     <= armed_d;
         req_q       <= req_d;
         req_write_q <= req_write_d;
         req_be_q    <= req_be_d;
      end
   end

   always_comb begin
      // NOTE: every next-state value and output gets a default first so no path infers a latch.
      state_d     = state_q;
      cnt_d       = cnt_q;
      armed_d     = armed_q | as_s;
      req_d       = 1'b0;
      req_write_d = req_write_q;
      req_be_d    = req_be_q;
      DATA_OE     = 1'b0;
      DTACK_OUT   = 1'b1;
      DTACK_OE    = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            // A held-low AS must be seen high again before it may start another access.
            if (!as_s && ds_any && SELECT && armed_q) begin
               state_d     = S_WAIT_ACK;
               req_d       = 1'b1;
               req_write_d = ~rw_s;
               req_be_d    = {~uds_s, ~lds_s};
               armed_d     = 1'b0;
            end
         end
         S_WAIT_ACK: begin
            if (as_s) begin
               state_d = S_IDLE;
            end else if (ACK) begin
               state_d = S_WAIT_CNT;
               cnt_d   = '0;
               DATA_OE = ~req_write_q;
            end
         end
         S_WAIT_CNT: begin
            DATA_OE = ~req_write_q;
            if (as_s) begin
               state_d = S_IDLE;
            end else if (cnt_q == WAIT_LAST) begin
               state_d = S_WAIT_EDGE;
            end else if (mc_fall_q) begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_WAIT_EDGE: begin
            DATA_OE = ~req_write_q;
            if (as_s) begin
               state_d = S_IDLE;
            end else if (mc_rise_q) begin
               state_d = S_ASSERT;
            end
         end
         S_ASSERT: begin
            DATA_OE   = ~req_write_q;
            DTACK_OE  = 1'b1;
            DTACK_OUT = 1'b0;
            if (as_s) begin
               state_d = S_RELEASE;
            end
         end
         S_RELEASE: begin
            // Drive DTACK high for one cycle before tristating so the pad does not float low.
            DTACK_OE = 1'b1;
            state_d  = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign REQ       = req_q;
   assign REQ_WRITE = req_write_q;
   assign REQ_BE    = req_be_q;

endmodule

// File: tb/tb_m68k_dtack_responder.sv
`timescale 1ns/1ps
// Bench for m68k_dtack_responder: two instances (0 and 3 wait states) share one 68000 bus,
// a transaction-level model is compared every cycle, and directed checks pin key latencies.
module tb_m68k_dtack_responder;

   localparam int WS_B = 3;

   logic clk;
   logic rst;
   logic mcclk;
   logic as_n;
   logic uds_n;
   logic lds_n;
   logic rw;
   logic sel;
   logic ack;

   logic       req0, wr0, doe0, dout0, oe0;
   logic [1:0] be0;
   logic       req3, wr3, doe3, dout3, oe3;
   logic [1:0] be3;
   logic [6:0] out0;
   logic [6:0] out3;

   assign out0 = {req0, wr0, be0, doe0, dout0, oe0};
   assign out3 = {req3, wr3, be3, doe3, dout3, oe3};

   m68k_dtack_responder #(.WAIT_STATES(0)) u_dut0 (
      .SYSCLK(clk), .RESET(rst), .MCCLK(mcclk), .AS(as_n), .UDS(uds_n), .LDS(lds_n), .RW(rw),
      .SELECT(sel), .REQ(req0), .REQ_WRITE(wr0), .REQ_BE(be0), .ACK(ack), .DATA_OE(doe0),
      .DTACK_OUT(dout0), .DTACK_OE(oe0)
   );

   m68k_dtack_responder #(.WAIT_STATES(WS_B)) u_dut3 (
      .SYSCLK(clk), .RESET(rst), .MCCLK(mcclk), .AS(as_n), .UDS(uds_n), .LDS(lds_n), .RW(rw),
      .SELECT(sel), .REQ(req3), .REQ_WRITE(wr3), .REQ_BE(be3), .ACK(ack), .DATA_OE(doe3),
      .DTACK_OUT(dout3), .DTACK_OE(oe3)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // MCCLK: 8 SYSCLK high, 8 low, changing between SYSCLK edges.
   int last_mc_rise = 0;
   int fall_toggles[$];
   initial begin
      mcclk = 1'b0;
      forever begin
         repeat (8) @(posedge clk);
         #1;
         mcclk = ~mcclk;
         if (mcclk) last_mc_rise = cyc;
         else       fall_toggles.push_back(cyc);
      end
   end

   // ---------------- transaction-level model ----------------
   logic [4:0] pin_h[$];
   bit         model_live = 1'b0;
   bit         m_as_now;
   bit         m_open[2], m_acked[2], m_ready[2], m_drive[2], m_neg[2];
   bit         m_armed[2], m_req[2], m_write[2];
   logic [1:0] m_be[2];
   int         m_falls[2];

   task automatic model_step(input int i, input int k);
      logic [4:0] s;
      bit as_s, ds_any, rise, fall;
      m_req[i] = 1'b0;
      m_as_now = (k >= 1) ? pin_h[k-1][3] : 1'b1;
      if (rst || k < 4) begin
         m_open[i] = 0; m_acked[i] = 0; m_ready[i] = 0; m_drive[i] = 0; m_neg[i] = 0;
         m_armed[i] = 0; m_write[i] = 0; m_be[i] = 2'b00; m_falls[i] = 0;
         return;
      end
      s      = pin_h[k-2];
      as_s   = s[3];
      ds_any = !s[2] || !s[1];
      rise   = pin_h[k-3][4] && !pin_h[k-4][4];
      fall   = !pin_h[k-3][4] && pin_h[k-4][4];
      if (m_neg[i]) begin
         m_neg[i] = 0;
      end else if (m_drive[i]) begin
         if (as_s) begin m_drive[i] = 0; m_neg[i] = 1; end
      end else if (m_open[i]) begin
         if (as_s) m_open[i] = 0;
         else if (!m_acked[i]) begin
            if (ack) begin m_acked[i] = 1; m_falls[i] = 0; m_ready[i] = 0; end
         end else if (!m_ready[i]) begin
            if (m_falls[i] == ((i == 0) ? 0 : WS_B)) m_ready[i] = 1;
            else if (fall) m_falls[i]++;
         end else if (rise) begin
            m_open[i] = 0; m_drive[i] = 1;
         end
      end else if (m_armed[i] && !as_s && ds_any && sel) begin
         m_open[i] = 1; m_acked[i] = 0; m_ready[i] = 0; m_req[i] = 1;
         m_write[i] = !s[0]; m_be[i] = {!s[2], !s[1]}; m_armed[i] = 0;
      end
      if (as_s) m_armed[i] = 1;
   endtask

   function automatic logic [6:0] model_out(input int i);
      bit rd, doe;
      rd  = !m_write[i];
      doe = rd && ((m_open[i] && m_acked[i]) || m_drive[i] ||
                   (m_open[i] && !m_acked[i] && ack && !m_as_now));
      return {m_req[i], m_write[i], m_be[i], doe, !m_drive[i], m_drive[i] || m_neg[i]};
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         pin_h.push_back({mcclk, as_n, uds_n, lds_n, rw});
         for (int i = 0; i < 2; i++) model_step(i, cyc);
         if (rst) model_live = 1'b1;
         cyc++;
      end
   end

   // ---------------- compare + event monitor ----------------
   int req_cnt = 0;
   int oe_rises[2];
   int oe_rise_cyc[2];
   int oe_rise_lat[2];
   int rel_pulses[2];
   bit doe_seen = 1'b0;
   bit oe_prev[2];

   initial begin
      for (int i = 0; i < 2; i++) begin
         oe_rises[i] = 0; oe_rise_cyc[i] = 0; oe_rise_lat[i] = 0; rel_pulses[i] = 0; oe_prev[i] = 0;
      end
      forever begin
         @(negedge clk);
         if (model_live) begin
            check("dut_ws0 outputs vs model", out0, model_out(0));
            check("dut_ws3 outputs vs model", out3, model_out(1));
            if (req0 === 1'b1) req_cnt++;
            if (doe0 === 1'b1 || doe3 === 1'b1) doe_seen = 1'b1;
            for (int i = 0; i < 2; i++) begin
               logic oe_v, dout_v;
               oe_v   = (i == 0) ? oe0 : oe3;
               dout_v = (i == 0) ? dout0 : dout3;
               if (oe_v === 1'b1 && !oe_prev[i]) begin
                  oe_rises[i]++;
                  oe_rise_cyc[i] = cyc;
                  oe_rise_lat[i] = cyc - last_mc_rise;
               end
               if (oe_v === 1'b1 && dout_v === 1'b1) rel_pulses[i]++;
               oe_prev[i] = (oe_v === 1'b1);
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got time %0t, expected finish earlier", $time);
      $fatal(1, "watchdog");
   end

   // ---------------- directed helpers ----------------
   task automatic wait_req(input string name, output int at);
      int n;
      n  = 0;
      at = -1;
      while (n < 40 && at < 0) begin
         @(negedge clk);
         if (req0 === 1'b1) at = cyc;
         n++;
      end
      check({name, " req seen within budget"}, (at >= 0), 1);
   endtask

   task automatic wait_dtack(input string name);
      int n, b0, b1;
      bit done;
      b0 = oe_rises[0];
      b1 = oe_rises[1];
      n = 0;
      done = 1'b0;
      while (!done && n < 120) begin
         @(negedge clk);
         #1;
         done = (oe_rises[0] > b0) && (oe_rises[1] > b1);
         n++;
      end
      check({name, " dtack seen within budget"}, done, 1);
   endtask

   task automatic wait_cyc(input int target);
      do @(negedge clk); while (cyc < target);
   endtask

   task automatic ack_after_req(input int c, output int a);
      tick();
      tick();
      ack = 1'b1;
      a = cyc;
      @(negedge clk);
   endtask

   task automatic release_bus(input string name, input bit read);
      int d;
      tick();
      as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
      d = cyc;
      wait_cyc(d + 2);
      check({name, " still asserting ws0"}, {dout0, oe0}, 2'b01);
      check({name, " still asserting ws3"}, {dout3, oe3}, 2'b01);
      wait_cyc(d + 3);
      check({name, " release pulse ws0"}, {dout0, oe0, doe0}, 3'b110);
      check({name, " release pulse ws3"}, {dout3, oe3, doe3}, 3'b110);
      wait_cyc(d + 4);
      check({name, " tristate ws0"}, {oe0, doe0}, 2'b00);
      check({name, " tristate ws3"}, {oe3, doe3}, 2'b00);
      if (read) check({name, " read data_oe was driven"}, doe_seen, 1);
      repeat (6) tick();
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      int d, c, a, nf, base_rel0, base_rel3, base_oe0, base_oe3;
      rst = 1'b1; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; rw = 1'b1; sel = 1'b0; ack = 1'b0;
      repeat (6) tick();
      rst = 1'b0;
      repeat (4) tick();
      @(negedge clk);
      check("reset outputs ws0", out0, 7'b0000010);
      check("reset outputs ws3", out3, 7'b0000010);

      // zero-wait read (ws0) and 3-wait read (ws3) on the same bus cycle
      tick();
      req_cnt = 0; doe_seen = 1'b0;
      as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0; rw = 1'b1; sel = 1'b1;
      d = cyc;
      wait_req("t1", c);
      check("t1 req latency", c - d, 3);
      check("t1 req_be", be0, 2'b11);
      check("t1 req_write", wr0, 1'b0);
      ack_after_req(c, a);
      check("t1 data_oe with ack ws0", doe0, 1'b1);
      check("t1 data_oe with ack ws3", doe3, 1'b1);
      tick();
      ack = 1'b0;
      check("t1 single req pulse", req_cnt, 1);
      wait_dtack("t1");
      check("t1 dtack after mc rise ws0", oe_rise_lat[0], 4);
      check("t1 dtack after mc rise ws3", oe_rise_lat[1], 4);
      nf = 0;
      foreach (fall_toggles[j]) begin
         if (fall_toggles[j] + 3 > a && fall_toggles[j] + 3 < oe_rise_cyc[1]) nf++;
      end
      check("t3 mc_fall count before dtack ws3", nf, WS_B);
      check("t1 dtack ws0 before ws3", (oe_rise_cyc[0] < oe_rise_cyc[1]), 1);
      release_bus("t1", 1'b1);

      // write with late data strobe
      req_cnt = 0; doe_seen = 1'b0;
      as_n = 1'b0; rw = 1'b0;
      repeat (10) tick();
      check("t2 no req before ds", req_cnt, 0);
      lds_n = 1'b0;
      d = cyc;
      wait_req("t2", c);
      check("t2 req latency after ds", c - d, 3);
      check("t2 req_be", be0, 2'b01);
      check("t2 req_write", wr0, 1'b1);
      ack_after_req(c, a);
      check("t2 no data_oe on write", {doe0, doe3}, 2'b00);
      tick();
      ack = 1'b0;
      wait_dtack("t2");
      release_bus("t2", 1'b0);
      check("t2 data_oe never driven", doe_seen, 1'b0);
      rw = 1'b1;

      // abort in WAIT_ACK, late ACK ignored
      req_cnt = 0;
      base_oe0 = oe_rises[0]; base_oe3 = oe_rises[1];
      as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0;
      wait_req("t4", c);
      tick();
      as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
      repeat (5) tick();
      ack = 1'b1;
      tick();
      ack = 1'b0;
      repeat (30) tick();
      check("t4 no dtack after abort ws0", oe_rises[0] - base_oe0, 0);
      check("t4 no dtack after abort ws3", oe_rises[1] - base_oe3, 0);
      check("t4 single req", req_cnt, 1);

      // held AS yields exactly one REQ
      req_cnt = 0;
      as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0;
      wait_req("t5", c);
      ack_after_req(c, a);
      tick();
      ack = 1'b0;
      wait_dtack("t5");
      repeat (200) tick();
      @(negedge clk);
      check("t5 one req while held", req_cnt, 1);
      check("t5 dtack held ws3", {dout3, oe3}, 2'b01);
      tick();
      as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
      repeat (6) tick();
      as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0;
      wait_req("t5 rearm", c);
      check("t5 second req after rearm", req_cnt, 2);
      ack_after_req(c, a);
      tick();
      ack = 1'b0;
      wait_dtack("t5 rearm");

      // reset in the middle of ASSERT
      base_rel0 = rel_pulses[0]; base_rel3 = rel_pulses[1];
      base_oe0  = oe_rises[0];   base_oe3  = oe_rises[1];
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("t6 reset outputs ws0", out0, 7'b0000010);
      check("t6 reset outputs ws3", out3, 7'b0000010);
      repeat (10) tick();
      check("t6 no release pulse ws0", rel_pulses[0] - base_rel0, 0);
      check("t6 no release pulse ws3", rel_pulses[1] - base_rel3, 0);
      check("t6 no dtack after reset", (oe_rises[0] - base_oe0) + (oe_rises[1] - base_oe3), 0);
      check("t6 held AS after reset gives no req", req_cnt, 2);
      as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
      repeat (6) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
